// File: rtl/axi_rr_arbiter.sv
// Two-requester round-robin arbiter for the shared AXI master port; holds a one-hot
// grant from request until B / last-R completion. Optional watchdog: define ARB_TIMEOUT_EN.
module axi_rr_arbiter #(
  parameter int ADDR_WID       = 32,
  parameter int DEC_MSB        = 31,
  parameter int DEC_LSB        = 26,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [1:0]            s_awvalid,
  input  logic [2*ADDR_WID-1:0] s_awaddr,
  input  logic [1:0]            s_arvalid,
  input  logic [2*ADDR_WID-1:0] s_araddr,
  input  logic                  m_bvalid,
  input  logic                  m_bready,
  input  logic                  m_rvalid,
  input  logic                  m_rready,
  input  logic                  m_rlast,
  output logic [1:0]            grant,
  output logic                  grant_wr,
  output logic                  grant_rd,
  output logic                  busy,
  output logic                  timeout_err
);

  typedef enum logic [1:0] {IDLE, WR, RD} state_t;

  if (TIMEOUT_CYCLES < 2) begin : g_param_chk
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  function automatic logic decode(input logic [ADDR_WID-1:0] addr);
    return addr[DEC_MSB:DEC_LSB] == '0;
  endfunction

  state_t     state_q, state_d;
  logic       last_q, last_d;
  logic       sel_q, sel_d;
  logic [1:0] wr_hit, rd_hit, req;
  logic       pick;
  logic       done;
  logic       tmo;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      wr_hit[i] = s_awvalid[i] & decode(s_awaddr[i*ADDR_WID +: ADDR_WID]);
      rd_hit[i] = s_arvalid[i] & decode(s_araddr[i*ADDR_WID +: ADDR_WID]);
    end
  end

  assign req  = wr_hit | rd_hit;
  // With both requesting, the one not served last wins; otherwise the lone requester.
  assign pick = (req == 2'b11) ? ~last_q : req[1];
  assign done = ((state_q == WR) & m_bvalid & m_bready) |
                ((state_q == RD) & m_rvalid & m_rready & m_rlast);

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter sits at zero in IDLE, so the first WR/RD cycle sees 0.
  always_comb begin
    cnt_d = '0;
    if (state_q != IDLE) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign tmo = (state_q != IDLE) && !done && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sel_d   = sel_q;
    unique case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          state_d = wr_hit[pick] ? WR : RD;
          sel_d   = pick;
          last_d  = pick;
        end
      end
      WR, RD: begin
        if (done || tmo) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
    end
  end

  assign grant       = (state_q == IDLE) ? 2'b00 : (sel_q ? 2'b10 : 2'b01);
  assign grant_wr    = (state_q == WR);
  assign grant_rd    = (state_q == RD);
  assign busy        = (state_q != IDLE);
  assign timeout_err = tmo;

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Scoreboard bench for axi_rr_arbiter: expected output changes are queued by the
// stimulus and popped by a monitor whenever the DUT outputs change.
module tb_axi_rr_arbiter;

  localparam int AW = 32;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b1;
  logic [1:0]    s_awvalid = '0;
  logic [2*AW-1:0] s_awaddr = '0;
  logic [1:0]    s_arvalid = '0;
  logic [2*AW-1:0] s_araddr = '0;
  logic          m_bvalid = 1'b0, m_bready = 1'b0;
  logic          m_rvalid = 1'b0, m_rready = 1'b0, m_rlast = 1'b0;
  logic [1:0]    grant;
  logic          grant_wr, grant_rd, busy, timeout_err;

  int total = 0;
  int bad   = 0;
  int ev    = 0;

  // {timeout_err, busy, grant_rd, grant_wr, grant}
  logic [5:0] exp_q[$];
  logic [5:0] prev = '0;

  axi_rr_arbiter #(.ADDR_WID(AW), .DEC_MSB(31), .DEC_LSB(26), .TIMEOUT_CYCLES(16)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_awvalid(s_awvalid), .s_awaddr(s_awaddr),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr),
    .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rlast(m_rlast),
    .grant(grant), .grant_wr(grant_wr), .grant_rd(grant_rd),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] g, input logic wr, input logic rd, input logic t);
    exp_q.push_back({t, |g, rd, wr, g});
  endtask

  task automatic edge1();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [5:0] outs();
    return {timeout_err, busy, grant_rd, grant_wr, grant};
  endfunction

  // Monitor: every change of the output tuple must match the next queued expectation.
  always @(negedge aclk) begin
    logic [5:0] cur;
    cur = outs();
    if (cur !== prev) begin
      ev++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_change#%0d: got %b expected no change", ev, cur);
      end else begin
        check($sformatf("event#%0d", ev), cur, exp_q.pop_front());
      end
    end
    prev = cur;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    #1 aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check("reset_outputs", outs(), 6'b000000);
    aresetn = 1'b1;

    // Single write from requester 0, then B completion.
    s_awaddr[0 +: AW] = 32'h0000_1000;
    s_awvalid = 2'b01;
    push(2'b01, 1'b1, 1'b0, 1'b0);
    edge1();
    check("wr0_grant", outs(), 6'b010101);
    s_awvalid = 2'b00;
    m_bvalid = 1'b1; m_bready = 1'b1;
    push(2'b00, 1'b0, 1'b0, 1'b0);
    edge1();
    m_bvalid = 1'b0; m_bready = 1'b0;
    check("wr0_release", outs(), 6'b000000);

    // Fresh reset so requester 0 wins first, then alternating writes.
    aresetn = 1'b0;
    #2 aresetn = 1'b1;
    s_awaddr = {32'h0000_2000, 32'h0000_1000};
    s_awvalid = 2'b11;
    push(2'b01, 1'b1, 1'b0, 1'b0);
    edge1();
    for (int k = 0; k < 3; k++) begin
      edge1();
      edge1();
      m_bvalid = 1'b1; m_bready = 1'b1;
      if (k == 2) s_awvalid = 2'b00;
      push(2'b00, 1'b0, 1'b0, 1'b0);
      edge1();
      m_bvalid = 1'b0; m_bready = 1'b0;
      check($sformatf("alt_idle%0d", k), outs(), 6'b000000);
      if (k < 2) push((k == 0) ? 2'b10 : 2'b01, 1'b1, 1'b0, 1'b0);
      edge1();
    end

    // Requester 0: write before its own read; read releases only on RLAST.
    s_araddr[0 +: AW] = 32'h0000_0100;
    s_awvalid = 2'b01;
    s_arvalid = 2'b01;
    push(2'b01, 1'b1, 1'b0, 1'b0);
    edge1();
    check("wr_first", outs(), 6'b010101);
    s_awvalid = 2'b00;
    m_bvalid = 1'b1; m_bready = 1'b1;
    push(2'b00, 1'b0, 1'b0, 1'b0);
    edge1();
    m_bvalid = 1'b0; m_bready = 1'b0;
    push(2'b01, 1'b0, 1'b1, 1'b0);
    edge1();
    check("rd_after_wr", outs(), 6'b011001);
    m_rvalid = 1'b1; m_rready = 1'b1; m_rlast = 1'b0;
    repeat (3) edge1();
    check("rd_hold_3beats", outs(), 6'b011001);
    m_rlast = 1'b1;
    s_arvalid = 2'b00;
    push(2'b00, 1'b0, 1'b0, 1'b0);
    edge1();
    m_rvalid = 1'b0; m_rready = 1'b0; m_rlast = 1'b0;
    check("rd_release_rlast", outs(), 6'b000000);

    // Out-of-window read on requester 1 never grants.
    s_araddr[AW +: AW] = 32'h0400_0000;
    s_arvalid = 2'b10;
    repeat (20) edge1();
    check("miss_no_grant", outs(), 6'b000000);
    s_arvalid = 2'b00;

    // Asynchronous reset in the middle of a read.
    s_araddr[AW +: AW] = 32'h0000_0040;
    s_arvalid = 2'b10;
    push(2'b10, 1'b0, 1'b1, 1'b0);
    edge1();
    check("rd1_grant", outs(), 6'b011010);
    s_arvalid = 2'b00;
    edge1();
    #1;
    push(2'b00, 1'b0, 1'b0, 1'b0);
    aresetn = 1'b0;
    #1;
    check("async_reset_drop", outs(), 6'b000000);
    edge1();
    aresetn = 1'b1;
    s_awaddr = {32'h0000_3000, 32'h0000_4000};
    s_awvalid = 2'b11;
    push(2'b01, 1'b1, 1'b0, 1'b0);
    edge1();
    check("post_reset_req0", outs(), 6'b010101);
    s_awvalid = 2'b00;
    m_bvalid = 1'b1; m_bready = 1'b1;
    push(2'b00, 1'b0, 1'b0, 1'b0);
    edge1();
    m_bvalid = 1'b0; m_bready = 1'b0;

    // Write with no B response.
    s_awaddr[0 +: AW] = 32'h0000_0800;
    s_awvalid = 2'b01;
    push(2'b01, 1'b1, 1'b0, 1'b0);
    edge1();
    s_awvalid = 2'b00;
`ifdef ARB_TIMEOUT_EN
    push(2'b01, 1'b1, 1'b0, 1'b1);
    push(2'b00, 1'b0, 1'b0, 1'b0);
    repeat (14) edge1();
    check("tmo_cycle15", outs(), 6'b010101);
    edge1();
    check("tmo_cycle16", outs(), 6'b110101);
    edge1();
    check("tmo_release", outs(), 6'b000000);
`else
    repeat (40) edge1();
    check("no_tmo_hold", outs(), 6'b010101);
    m_bvalid = 1'b1; m_bready = 1'b1;
    push(2'b00, 1'b0, 1'b0, 1'b0);
    edge1();
    m_bvalid = 1'b0; m_bready = 1'b0;
`endif

    repeat (3) edge1();
    check("scoreboard_drained", 6'(exp_q.size()), 6'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_rr_arbiter.md
# axi_rr_arbiter

Two-requester round-robin arbitration controller for the shared AXI master port of the interconnect. It watches write-address and read-address requests from upstream slave interfaces 0 and 1 and decodes each address against the master's window. It then issues a one-hot grant that the datapath mux uses to connect exactly one requester to the master port, and holds that grant until the transaction's response completes. It replaces fixed requester-1-first priority with fair alternation and adds an optional stall watchdog.

## Interface
- ADDR_WID, 32, address width
- DEC_MSB, 31, top bit of the window-decode field
- DEC_LSB, 26, bottom bit of the window-decode field; a request hits when addr[DEC_MSB:DEC_LSB] == 0
- TIMEOUT_CYCLES, 1024, watchdog limit in aclk cycles (≥2)

Ports:
- aclk  in  1  clock, all logic on posedge
- aresetn  in  1  reset, asynchronous, active-low
- s_awvalid  in  2  per-requester AWVALID, bit i = requester i
- s_awaddr  in  2*ADDR_WID  packed AWADDR, requester i in [i*ADDR_WID +: ADDR_WID]
- s_arvalid  in  2  per-requester ARVALID
- s_araddr  in  2*ADDR_WID  packed ARADDR
- m_bvalid  in  1  BVALID from master port
- m_bready  in  1  BREADY as forwarded to master port by mux
- m_rvalid  in  1  RVALID from master port
- m_rready  in  1  RREADY as forwarded by mux
- m_rlast  in  1  RLAST from master port
- grant  out  2  one-hot requester select, 0 = none
- grant_wr  out  1  granted transaction is a write
- grant_rd  out  1  granted transaction is a read
- busy  out  1  any grant active
- timeout_err  out  1  one-cycle pulse on watchdog abort

## Operation
- States: IDLE, WR, RD. Reset: state IDLE, all outputs 0, last_grant = 1, so requester 0 wins first.
- Hit per requester i: wr_hit[i] = s_awvalid[i] & decode(awaddr_i); rd_hit[i] = s_arvalid[i] & decode(araddr_i). req[i] = wr_hit[i] | rd_hit[i].
- IDLE: if no req, stay. If one req, pick it. If both, pick the requester ≠ last_grant. For the chosen requester, write takes precedence over read. Go to WR or RD, set grant[i], update last_grant = i.
- WR: leave to IDLE on the cycle where m_bvalid & m_bready.
- RD: leave to IDLE on the cycle where m_rvalid & m_rready & m_rlast.
- Leaving WR/RD clears grant, grant_wr, grant_rd, and busy.
- Requests with no address hit are ignored. They never grant and never move last_grant.
- Request withdrawal while granted is ignored; the grant holds until completion or timeout.
- A requester's pending read waits behind its own write; with both requesters active, grants alternate 0,1,0,1.

## Timing
- Grant latency: request sampled at edge N; grant, grant_wr/grant_rd and busy are registered and high after edge N.
- Release: completion handshake sampled at edge M; outputs are 0 after edge M.
- IDLE lasts at least one cycle between grants, so there are no back-to-back grants. A request pending at edge M is evaluated at edge M+1.
- Completion and a new request in the same cycle: completion wins. The new request is arbitrated from IDLE on the next edge.
- aresetn low mid-transaction: outputs drop to 0 immediately (asynchronously), state goes to IDLE, last_grant = 1, and the watchdog clears.
- grant is never multi-hot. grant_wr and grant_rd are mutually exclusive and each implies busy.

## Configuration
- ARB_TIMEOUT_EN defined:
  - a $clog2(TIMEOUT_CYCLES)-bit counter clears on entry to WR/RD and increments every cycle in WR/RD;
  - in the state's TIMEOUT_CYCLES-th cycle without completion, the FSM forces IDLE and timeout_err pulses high for exactly that one cycle;
  - if completion and timeout coincide, completion wins and there is no pulse.
- ARB_TIMEOUT_EN undefined: no counter, timeout_err tied 0, and the grant is held indefinitely until completion.

## Test plan
- Reset, then s_awvalid=2'b01 with awaddr0=0x0000_1000 → grant=01 and grant_wr=1 one cycle later; m_bvalid=m_bready=1 → grant=00 the next cycle.
- s_awvalid=2'b11, both addresses in window, held → grants alternate 01,10,01 across three write completions, with one IDLE cycle between each.
- Requester 0 with s_awvalid and s_arvalid both hit → WR first; after B completes, RD; RD holds through 4 beats and releases only on the rlast beat.
- s_araddr1=0x0400_0000 (bit 26 set) with s_arvalid[1]=1 → grant stays 00 and busy stays 0 indefinitely.
- aresetn pulsed low during RD → grant, grant_rd and busy go 0 without a clock edge; the next dual request grants requester 0.
- ARB_TIMEOUT_EN with TIMEOUT_CYCLES=16, write granted and no B response → timeout_err is a single pulse in the 16th WR cycle, and grant=00 on the following cycle.
